// File: rtl/pipeline_skid_stage_if.sv
// Valid/ready handshake bundle carrying one WIDTH-bit stage word.
// master drives valid/data and samples ready; slave is the mirror image.
interface pipeline_skid_stage_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_skid_stage.sv
// Elastic inter-stage register: output register plus one-entry skid buffer, registered ready.
// Define PIPE_STAGE_STALL_CNT_EN to build the saturating downstream stall counter.
module pipeline_skid_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipeline_skid_stage_if.slave  up,
  pipeline_skid_stage_if.master dn,
  output logic [31:0]           stall_count
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             in_fire;
  logic             out_free;

  // ready comes straight off the skid flop so downstream stalls never ripple upstream
  assign up.ready = ~skid_vld_q;
  assign dn.valid = valid_q;
  assign dn.data  = data_q;

  assign in_fire  = up.valid & ~skid_vld_q;
  assign out_free = ~valid_q | dn.ready;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (flush) begin
      valid_d    = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_free) begin
      if (skid_vld_q) begin
        data_d     = skid_dat_q;
        valid_d    = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        data_d  = up.data;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_dat_d = up.data;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= RESET_VAL;
      skid_vld_q <= 1'b0;
      skid_dat_q <= RESET_VAL;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // flush deliberately leaves the count alone; only reset clears it
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !dn.ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= 32'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule
